descrambler_frame_aligner: RTL and testbench

DESCRAMBLER_FRAME_ALIGNER -- requirements
Module: descrambler_frame_aligner

---
 rtl/descrambler_frame_aligner.sv | 169 ++++++++++++++++
 tb/tb_descrambler_frame_aligner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/descrambler_frame_aligner.sv
// Frame aligner that sits in front of a 64b/66b-style descrambler.
// It hunts for the bit offset at which a 2-bit sync header is valid, confirms
// that offset over LOCK_COUNT consecutive frames, and then forwards the 30-bit
// payloads. While locked it watches header errors in windows of WINDOW_LEN
// words and drops lock if UNLOCK_BAD errors land in one window.
//
// Ports
//   clock            sole clock, all state updates on the rising edge
//   reset            synchronous, active-low
//   wordIn[31:0]     deserializer word, bit 0 earliest in time
//   wordValid        qualifies wordIn
//   frameOut[29:0]   payload of the aligned frame (descrambler frameIn)
//   frameValid       qualifies frameOut
//   deScrambleEnable high for data frames (header 2'b10)
//   headerOut[1:0]   header of the aligned frame
//   headerError      invalid header on a forwarded frame
//   locked           aligner is in LOCKED
//   slipOffset[4:0]  current bit offset 0..31
module descrambler_frame_aligner #(
  parameter int unsigned LOCK_COUNT = 32,
  parameter int unsigned UNLOCK_BAD = 8,
  parameter int unsigned WINDOW_LEN = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] wordIn,
  input  logic        wordValid,
  output logic [29:0] frameOut,
  output logic        frameValid,
  output logic        deScrambleEnable,
  output logic [1:0]  headerOut,
  output logic        headerError,
  output logic        locked,
  output logic [4:0]  slipOffset
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BAD_W  = $clog2(UNLOCK_BAD + 1);
  localparam int unsigned WIN_W  = $clog2(WINDOW_LEN + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        prev_word;
  logic [GOOD_W-1:0]  good_count;
  logic [BAD_W-1:0]   bad_count;
  logic [WIN_W-1:0]   win_count;

  logic [63:0]        window_c;
  logic [31:0]        extracted_c;
  logic [1:0]         header_c;
  logic [29:0]        payload_c;
  logic               header_ok_c;
  logic [GOOD_W-1:0]  good_inc_c;
  logic               good_done_c;
  logic [BAD_W-1:0]   bad_inc_c;
  logic               bad_done_c;
  logic [WIN_W-1:0]   win_inc_c;
  logic               win_done_c;

  // Frame extraction: window bits [63-slip : 32-slip], header in the two earliest bits.
  always_comb begin
    window_c    = {wordIn, prev_word};
    extracted_c = 32'(window_c >> (6'd32 - {1'b0, slipOffset}));
    header_c    = extracted_c[1:0];
    payload_c   = extracted_c[31:2];
    header_ok_c = (header_c == 2'b10) || (header_c == 2'b01);
  end

  // Counter increments and their thresholds.
  always_comb begin
    good_inc_c  = good_count + GOOD_W'(1);
    good_done_c = (good_inc_c == GOOD_W'(LOCK_COUNT));
    bad_inc_c   = bad_count + BAD_W'(1);
    bad_done_c  = !header_ok_c && (bad_inc_c == BAD_W'(UNLOCK_BAD));
    win_inc_c   = win_count + WIN_W'(1);
    win_done_c  = (win_inc_c == WIN_W'(WINDOW_LEN));
  end

  // Alignment FSM, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= HUNT;
      prev_word        <= '0;
      good_count       <= '0;
      bad_count        <= '0;
      win_count        <= '0;
      slipOffset       <= '0;
      frameOut         <= '0;
      headerOut        <= '0;
      frameValid       <= 1'b0;
      deScrambleEnable <= 1'b0;
      headerError      <= 1'b0;
      locked           <= 1'b0;
    end else begin
      // Per-frame strobes default low; frameOut/headerOut hold.
      frameValid       <= 1'b0;
      deScrambleEnable <= 1'b0;
      headerError      <= 1'b0;

      if (wordValid) begin
        prev_word <= wordIn;
        case (state)
          HUNT: begin
            if (header_ok_c) begin
              good_count <= GOOD_W'(1);
              state      <= VERIFY;
            end else begin
              slipOffset <= slipOffset + 5'd1;
            end
          end

          VERIFY: begin
            if (header_ok_c) begin
              good_count <= good_inc_c;
              if (good_done_c) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                win_count <= '0;
                bad_count <= '0;
              end
            end else begin
              good_count <= '0;
              slipOffset <= slipOffset + 5'd1;
              state      <= HUNT;
            end
          end

          LOCKED: begin
            // Every word seen while already locked is forwarded, bad header or not.
            frameValid       <= 1'b1;
            frameOut         <= payload_c;
            headerOut        <= header_c;
            deScrambleEnable <= (header_c == 2'b10);
            headerError      <= !header_ok_c;

            // Threshold check first so a bad last word still closes its own window.
            if (bad_done_c) begin
              state      <= HUNT;
              locked     <= 1'b0;
              slipOffset <= slipOffset + 5'd1;
              good_count <= '0;
              win_count  <= '0;
              bad_count  <= '0;
            end else if (win_done_c) begin
              win_count <= '0;
              bad_count <= '0;
            end else begin
              win_count <= win_inc_c;
              if (!header_ok_c) begin
                bad_count <= bad_inc_c;
              end
            end
          end

          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_descrambler_frame_aligner.sv
// Directed table-driven bench for descrambler_frame_aligner.
module tb_descrambler_frame_aligner;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] wordIn = '0;
  logic        wordValid = 1'b0;
  logic [29:0] frameOut;
  logic        frameValid;
  logic        deScrambleEnable;
  logic [1:0]  headerOut;
  logic        headerError;
  logic        locked;
  logic [4:0]  slipOffset;

  always #5 clock = ~clock;

  descrambler_frame_aligner dut (
    .clock            (clock),
    .reset            (reset),
    .wordIn           (wordIn),
    .wordValid        (wordValid),
    .frameOut         (frameOut),
    .frameValid       (frameValid),
    .deScrambleEnable (deScrambleEnable),
    .headerOut        (headerOut),
    .headerError      (headerError),
    .locked           (locked),
    .slipOffset       (slipOffset)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] word;
    logic        fv;
    logic        dse;
    logic        he;
    logic        lk;
    logic [4:0]  slip;
    logic [29:0] frame;
    logic [1:0]  hdr;
  } vec_t;

  vec_t        vq[$];
  logic [29:0] last_frame = '0;
  logic [1:0]  last_hdr = '0;
  int          errors = 0;
  int          checks = 0;

  localparam logic [29:0] AP = 30'h2AAAAAAA;
  localparam logic [29:0] BP = 30'h1234567;
  localparam logic [29:0] CP = 30'h0000155;

  // Append a row; frame/header expectation holds its last value when fv=0.
  task automatic add(input logic rst, input logic vld, input logic [31:0] w,
                     input logic fv, input logic dse, input logic he, input logic lk,
                     input logic [4:0] slip, input logic [29:0] fr, input logic [1:0] hd);
    vec_t v;
    if (!rst) begin
      last_frame = '0;
      last_hdr   = '0;
    end else if (fv) begin
      last_frame = fr;
      last_hdr   = hd;
    end
    v.rst = rst; v.vld = vld; v.word = w;
    v.fv = rst ? fv : 1'b0;
    v.dse = rst ? dse : 1'b0;
    v.he = rst ? he : 1'b0;
    v.lk = rst ? lk : 1'b0;
    v.slip = rst ? slip : 5'd0;
    v.frame = last_frame;
    v.hdr = last_hdr;
    vq.push_back(v);
  endtask

  task automatic check(input int row, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got 0x%0h expected 0x%0h", row, nm, act, exp);
    end
  endtask

  initial begin
    logic [30:0] lfsr;
    logic [29:0] pay[40];
    logic        sbits[$];
    logic [31:0] fw;
    logic [31:0] w;

    // ---- reset with traffic ----
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, $urandom, 0, 0, 0, 0, 5'd0, '0, '0);

    // ---- aligned lock at offset 0 (first row is the release cycle) ----
    for (int j = 0; j < 32; j++) begin
      add(1'b1, 1'b1, {AP, 2'b10}, 0, 0, 0, (j == 31), 5'd0, '0, '0);
      if (j == 9) add(1'b1, 1'b0, $urandom, 0, 0, 0, 0, 5'd0, '0, '0);
    end
    add(1'b1, 1'b1, {AP, 2'b10}, 1, 1, 0, 1, 5'd0, AP, 2'b10);

    // ---- control frame ----
    add(1'b1, 1'b1, {CP, 2'b01}, 1, 0, 0, 1, 5'd0, CP, 2'b01);

    // ---- 7 bad headers in one window, the last on the 64th word ----
    for (int i = 0; i < 6; i++) begin
      add(1'b1, 1'b1, {AP, 2'b10}, 1, 1, 0, 1, 5'd0, AP, 2'b10);
      if (i == 2) add(1'b1, 1'b1, {BP, 2'b11}, 1, 0, 1, 1, 5'd0, BP, 2'b11);
      else        add(1'b1, 1'b1, {BP, 2'b00}, 1, 0, 1, 1, 5'd0, BP, 2'b00);
    end
    add(1'b1, 1'b0, $urandom, 0, 0, 0, 1, 5'd0, '0, '0);
    for (int i = 0; i < 49; i++) add(1'b1, 1'b1, {AP, 2'b10}, 1, 1, 0, 1, 5'd0, AP, 2'b10);
    add(1'b1, 1'b1, {BP, 2'b00}, 1, 0, 1, 1, 5'd0, BP, 2'b00);

    // ---- 8 bad headers in the next window force unlock ----
    for (int i = 0; i < 8; i++) begin
      add(1'b1, 1'b1, {BP, 2'b00}, 1, 0, 1, (i < 7), (i == 7) ? 5'd1 : 5'd0, BP, 2'b00);
      if (i < 7) add(1'b1, 1'b1, {AP, 2'b10}, 1, 1, 0, 1, 5'd0, AP, 2'b10);
    end
    add(1'b1, 1'b0, $urandom, 0, 0, 0, 0, 5'd1, '0, '0);
    add(1'b1, 1'b0, $urandom, 0, 0, 0, 0, 5'd1, '0, '0);
    // At offset 1 the header straddles BP[29]=0 and the new word's bit 0=0 -> invalid.
    add(1'b1, 1'b1, {AP, 2'b10}, 0, 0, 0, 0, 5'd2, '0, '0);

    // ---- slip to a frame boundary at offset 5 ----
    add(1'b0, 1'b1, $urandom, 0, 0, 0, 0, 5'd0, '0, '0);
    lfsr = 31'h1;
    for (int f = 0; f < 40; f++) begin
      for (int s = 0; s < 7; s++) lfsr = {lfsr[29:0], lfsr[30] ^ lfsr[27]};
      // Payload bits 3:0 set so offsets 1..4 see an 11 header.
      pay[f] = 30'(lfsr) | 30'hF;
    end
    for (int b = 0; b < 27; b++) sbits.push_back(1'b0);
    for (int f = 0; f < 40; f++) begin
      fw = {pay[f], 2'b10};
      for (int b = 0; b < 32; b++) sbits.push_back(fw[b]);
    end
    for (int k = 0; k < 40; k++) begin
      for (int b = 0; b < 32; b++) w[b] = sbits[32 * k + b];
      if (k >= 37)
        add(1'b1, 1'b1, w, 1, 1, 0, 1, 5'd5, pay[k - 1], 2'b10);
      else
        add(1'b1, 1'b1, w, 0, 0, 0, (k >= 36), (k < 5) ? 5'(k + 1) : 5'd5, '0, '0);
    end

    // ---- reset while locked ----
    add(1'b0, 1'b1, $urandom, 0, 0, 0, 0, 5'd0, '0, '0);
    add(1'b1, 1'b0, $urandom, 0, 0, 0, 0, 5'd0, '0, '0);

    // ---- apply the table ----
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock);
      reset     = vq[i].rst;
      wordValid = vq[i].vld;
      wordIn    = vq[i].word;
      @(posedge clock);
      #1;
      check(i, "frameValid",       32'(frameValid),       32'(vq[i].fv));
      check(i, "deScrambleEnable", 32'(deScrambleEnable), 32'(vq[i].dse));
      check(i, "headerError",      32'(headerError),      32'(vq[i].he));
      check(i, "locked",           32'(locked),           32'(vq[i].lk));
      check(i, "slipOffset",       32'(slipOffset),       32'(vq[i].slip));
      check(i, "frameOut",         32'(frameOut),         32'(vq[i].frame));
      check(i, "headerOut",        32'(headerOut),        32'(vq[i].hdr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
